// File: rtl/sign_pkg.sv
// Shared definitions for sign-magnitude / two's-complement conversion blocks.
// Used by sign_restore and by the abs block for its most-negative constant.
package sign_pkg;

  localparam int unsigned DwDefault = 8;

  // Range-check results produced by the first pipeline stage.
  typedef struct packed {
    logic sign;
    logic pos_ovf;
    logic neg_ovf;
    logic neg_zero;
  } s1_flags_t;

  // Largest positive value representable in dw-bit two's complement.
  function automatic logic [63:0] max_pos(input int unsigned dw);
    return (64'd1 << (dw - 1)) - 64'd1;
  endfunction

  // Bit pattern of the most negative dw-bit value; also equals max_pos + 1 as a magnitude.
  function automatic logic [63:0] min_neg(input int unsigned dw);
    return 64'd1 << (dw - 1);
  endfunction

endpackage

// File: rtl/sign_restore_pipe_stage.sv
// Generic valid/ready register slice. Accepts a new beat in the same cycle it
// hands its held beat downstream; holds payload stable while stalled.
module pipe_stage #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data
);

  assign in_ready = !out_valid | out_ready;

  // Load when empty or when the held beat leaves this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/sign_restore.sv
// Streaming sign-magnitude to two's-complement converter with saturation.
// Stage 1 registers the input with its range flags; stage 2 registers the result.
// Optional saturation event counter: define SIGN_RESTORE_SAT_CNT_EN.
module sign_restore
  import sign_pkg::*;
#(
  parameter int unsigned DW    = DwDefault,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [DW-1:0]    in_mag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic             out_sat
`ifdef SIGN_RESTORE_SAT_CNT_EN
  ,
  output logic [CNT_W-1:0] sat_cnt,
  input  logic             sat_cnt_clr
`endif
);

  localparam logic [DW-1:0] MaxP = DW'(max_pos(DW));
  localparam logic [DW-1:0] MinN = DW'(min_neg(DW));

  typedef struct packed {
    s1_flags_t     flags;
    logic [DW-1:0] mag;
  } s1_t;

  typedef struct packed {
    logic          sat;
    logic [DW-1:0] data;
  } s2_t;

  if (DW < 2 || CNT_W < 1) begin : g_param_check
    $error("sign_restore: DW must be >= 2 and CNT_W >= 1");
  end

  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  logic s1_in_ready, s1_valid, s2_in_ready;

  // Range check on the incoming beat; MinN doubles as MAXP+1 in magnitude terms.
  always_comb begin
    s1_d.mag            = in_mag;
    s1_d.flags.sign     = in_sign;
    s1_d.flags.pos_ovf  = !in_sign && (in_mag > MaxP);
    s1_d.flags.neg_ovf  = in_sign && (in_mag > MinN);
    s1_d.flags.neg_zero = in_sign && (in_mag == '0);
  end

  // Held in reset so upstream never sees a ready it cannot honour.
  assign in_ready = rst_n & s1_in_ready;

  pipe_stage #(
    .Width($bits(s1_t))
  ) u_stage1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (s1_in_ready),
    .in_data  (s1_d),
    .out_valid(s1_valid),
    .out_ready(s2_in_ready),
    .out_data (s1_q)
  );

  // Conversion; -(MAXP+1) falls out of plain negation without saturating.
  always_comb begin
    s2_d.sat  = 1'b0;
    s2_d.data = s1_q.mag;
    if (s1_q.flags.pos_ovf) begin
      s2_d.sat  = 1'b1;
      s2_d.data = MaxP;
    end else if (s1_q.flags.neg_ovf) begin
      s2_d.sat  = 1'b1;
      s2_d.data = MinN;
    end else if (s1_q.flags.neg_zero) begin
      s2_d.data = '0;
    end else if (s1_q.flags.sign) begin
      s2_d.data = (~s1_q.mag) + DW'(1);
    end
  end

  pipe_stage #(
    .Width($bits(s2_t))
  ) u_stage2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (s1_valid),
    .in_ready (s2_in_ready),
    .in_data  (s2_d),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (s2_q)
  );

  assign out_data = s2_q.data;
  assign out_sat  = s2_q.sat;

`ifdef SIGN_RESTORE_SAT_CNT_EN
  // Count saturated output transfers; sticks at all-ones, clear wins over increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (sat_cnt_clr) begin
      sat_cnt <= '0;
    end else if (out_valid && out_ready && out_sat && (sat_cnt != '1)) begin
      sat_cnt <= sat_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_sign_restore.sv
// Self-checking bench for sign_restore: queue-based reference model plus
// directed literal vectors, backpressure, mid-stream reset and counter checks.
`timescale 1ns/1ps
module tb_sign_restore;

  localparam int unsigned DW = 8;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          in_sign   = 1'b0;
  logic [DW-1:0] in_mag    = '0;
  logic          out_ready = 1'b1;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_sat;
`ifdef SIGN_RESTORE_SAT_CNT_EN
  logic          sat_cnt_clr = 1'b0;
  logic [15:0]   sat_cnt;
  logic [1:0]    sat_cnt2;
  logic          in_ready2, out_valid2, out_sat2;
  logic [DW-1:0] out_data2;
`endif

  int tests = 0;
  int fails = 0;
  int out_count = 0;
  logic [8:0] exp_q[$];
  bit   rst_seen   = 1'b0;
  bit   prev_stall = 1'b0;
  logic [8:0] prev_out = '0;
  bit   bp_on;

  always #5 clk = ~clk;

  sign_restore #(
    .DW   (DW),
    .CNT_W(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_mag     (in_mag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat)
`ifdef SIGN_RESTORE_SAT_CNT_EN
    ,
    .sat_cnt    (sat_cnt),
    .sat_cnt_clr(sat_cnt_clr)
`endif
  );

`ifdef SIGN_RESTORE_SAT_CNT_EN
  sign_restore #(
    .DW   (DW),
    .CNT_W(2)
  ) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready2),
    .in_sign    (in_sign),
    .in_mag     (in_mag),
    .out_valid  (out_valid2),
    .out_ready  (out_ready),
    .out_data   (out_data2),
    .out_sat    (out_sat2),
    .sat_cnt    (sat_cnt2),
    .sat_cnt_clr(sat_cnt_clr)
  );
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: signed value from sign and magnitude, clamped to the 8-bit range.
  function automatic logic [8:0] ref_conv(input bit s, input logic [7:0] m);
    int v;
    v = s ? -int'(m) : int'(m);
    if (v > 127)  return {1'b1, 8'h7F};
    if (v < -128) return {1'b1, 8'h80};
    return {1'b0, 8'(v)};
  endfunction

  // Compare process: sampled on the falling edge, mirrors transfers due at the next rising edge.
  always @(negedge clk) begin
    if (rst_seen) check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    if (!rst_n) begin
      check("reset_in_ready", {31'd0, in_ready}, 32'd0);
      exp_q.delete();
      prev_stall = 1'b0;
      rst_seen   = 1'b1;
    end else begin
      rst_seen = 1'b0;
      check("in_ready_rule", {31'd0, in_ready},
            {31'd0, (exp_q.size() < 2) || (out_ready == 1'b1)});
      if (prev_stall) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_payload", {23'd0, out_sat, out_data}, {23'd0, prev_out});
      end
      if (out_valid && exp_q.size() == 0) begin
        check("spurious_out", {31'd0, out_valid}, 32'd0);
      end
      if (out_valid && out_ready && exp_q.size() > 0) begin
        check("out_beat", {23'd0, out_sat, out_data}, {23'd0, exp_q.pop_front()});
        out_count++;
      end
      if (in_valid && in_ready) exp_q.push_back(ref_conv(in_sign, in_mag));
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_sat, out_data};
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send_beat(input bit s, input logic [7:0] m);
    bit acc;
    int guard;
    acc   = 1'b0;
    guard = 0;
    in_valid = 1'b1;
    in_sign  = s;
    in_mag   = m;
    do begin
      @(negedge clk);
      acc = in_ready;
      guard++;
      @(posedge clk);
      #1;
    end while (!acc && guard < 200);
    check("send_accept", {31'd0, acc}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() > 0 && g < 100) begin
      @(posedge clk);
      g++;
    end
    #1;
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  // Single beat with out_ready high: result must appear exactly two edges after acceptance.
  task automatic directed(input bit s, input logic [7:0] m, input logic [7:0] ed, input bit es);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sign   = s;
    in_mag    = m;
    @(negedge clk);
    check($sformatf("dir_accept_%0d_%0d", s, m), {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check($sformatf("dir_lat1_%0d_%0d", s, m), {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check($sformatf("dir_lat2_%0d_%0d", s, m), {31'd0, out_valid}, 32'd1);
    check($sformatf("dir_data_%0d_%0d", s, m), {24'd0, out_data}, {24'd0, ed});
    check($sformatf("dir_sat_%0d_%0d", s, m), {31'd0, out_sat}, {31'd0, es});
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int g;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    directed(1'b0, 8'd5,   8'h05, 1'b0);
    directed(1'b1, 8'd5,   8'hFB, 1'b0);
    directed(1'b0, 8'd127, 8'h7F, 1'b0);
    directed(1'b0, 8'd128, 8'h7F, 1'b1);
    directed(1'b1, 8'd128, 8'h80, 1'b0);
    directed(1'b1, 8'd200, 8'h80, 1'b1);
    directed(1'b1, 8'd0,   8'h00, 1'b0);
    directed(1'b1, 8'd127, 8'h81, 1'b0);
    directed(1'b1, 8'd129, 8'h80, 1'b1);
    directed(1'b0, 8'd255, 8'h7F, 1'b1);

    // Back-to-back stream at full rate.
    base = out_count;
    for (int i = 0; i < 16; i++) send_beat(i[0], 8'(i * 17));
    drain();
    check("stream_count", out_count - base, 32'd16);

    // Backpressure: out_ready toggles every 3 cycles while 10 negative beats stream in.
    base = out_count;
    out_ready = 1'b0;
    bp_on = 1'b1;
    fork
      begin
        for (int i = 1; i <= 10; i++) send_beat(1'b1, 8'(i));
        bp_on = 1'b0;
      end
      begin
        while (bp_on) begin
          repeat (3) @(posedge clk);
          #1 out_ready = ~out_ready;
        end
      end
    join
    out_ready = 1'b1;
    drain();
    check("bp_count", out_count - base, 32'd10);

    // Random traffic with random backpressure.
    base = out_count;
    fork
      begin
        for (int i = 0; i < 30; i++) send_beat(1'($urandom), 8'($urandom));
        bp_on = 1'b0;
      end
      begin
        bp_on = 1'b1;
        while (bp_on) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom);
        end
      end
    join
    out_ready = 1'b1;
    drain();
    check("rand_count", out_count - base, 32'd30);

    // Reset with two beats in flight: nothing may emerge afterwards.
    out_ready = 1'b0;
    send_beat(1'b0, 8'd3);
    send_beat(1'b0, 8'd4);
    base = out_count;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("reset_no_stale", out_count - base, 32'd0);
    check("reset_idle_valid", {31'd0, out_valid}, 32'd0);

`ifdef SIGN_RESTORE_SAT_CNT_EN
    sat_cnt_clr = 1'b1;
    @(posedge clk);
    #1 sat_cnt_clr = 1'b0;
    check("cnt_clr_idle", {16'd0, sat_cnt}, 32'd0);
    send_beat(1'b0, 8'd128);
    send_beat(1'b1, 8'd200);
    send_beat(1'b0, 8'd255);
    send_beat(1'b0, 8'd1);
    send_beat(1'b1, 8'd1);
    drain();
    check("cnt_three", {16'd0, sat_cnt}, 32'd3);
    check("cnt2_three", {30'd0, sat_cnt2}, 32'd3);
    send_beat(1'b0, 8'd200);
    send_beat(1'b1, 8'd129);
    drain();
    check("cnt_five", {16'd0, sat_cnt}, 32'd5);
    check("cnt2_sticky", {30'd0, sat_cnt2}, 32'd3);
    // Clear coinciding with a saturated output transfer.
    out_ready = 1'b0;
    send_beat(1'b0, 8'd250);
    g = 0;
    while (!out_valid && g < 10) begin
      @(negedge clk);
      g++;
    end
    check("cnt_wait_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    base = out_count;
    #1 out_ready = 1'b1;
    sat_cnt_clr = 1'b1;
    @(posedge clk);
    #1 sat_cnt_clr = 1'b0;
    check("cnt_clr_wins", {16'd0, sat_cnt}, 32'd0);
    check("cnt_clr_xfer", out_count - base, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
